// File: rtl/hilo_div_ctrl_if.sv
// Bus between the HI/LO divide controller, the multicycle control unit and
// the restoring divider. The slave side is the controller; the master side is
// whatever sits around it (control unit plus divider).
interface hilo_div_ctrl_if;
    // control unit -> controller
    logic        div_req;
    logic        mthi;
    logic        mtlo;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    // controller <-> divider
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_end;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    // controller -> control unit
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy;
    logic        done;
    logic        div0_exc;
    logic        timeout_err;

    modport slave (
        input  div_req, mthi, mtlo, rs_data, rt_data,
        input  div_end, div_hi, div_lo,
        output div_start, div_a, div_b,
        output hi_q, lo_q, busy, done, div0_exc, timeout_err
    );

    modport master (
        output div_req, mthi, mtlo, rs_data, rt_data,
        output div_end, div_hi, div_lo,
        input  div_start, div_a, div_b,
        input  hi_q, lo_q, busy, done, div0_exc, timeout_err
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO divide controller: screens divide-by-zero, launches the unsigned
// restoring divider with a one-cycle start, waits (bounded) for its end flag
// and commits the remainder/quotient into the architectural HI/LO registers.
// MTHI/MTLO writes are serviced while idle.
module hilo_div_ctrl #(
    parameter int MAX_WAIT = 40  // 33..255, wait counter is 8 bits
) (
    input  logic             clock,
    input  logic             reset,
    hilo_div_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        done_q, done_d;
    logic        div0_exc_q, div0_exc_d;
    logic        timeout_err_q, timeout_err_d;

    // Next-state and next-register computation for the controller FSM
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        div_a_d       = div_a_q;
        div_b_d       = div_b_q;
        wait_cnt_d    = wait_cnt_q;
        done_d        = 1'b0;
        div0_exc_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // div_req wins; a coincident MTHI/MTLO is dropped.
                if (bus.div_req) begin
                    if (bus.rt_data == 32'd0) begin
                        div0_exc_d = 1'b1;
                    end else begin
                        div_a_d = bus.rs_data;
                        div_b_d = bus.rt_data;
                        state_d = S_ISSUE;
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.rs_data;
                    if (bus.mtlo) lo_d = bus.rs_data;
                end
            end
            S_ISSUE: begin
                // div_end may still be high from the previous op; not looked at here.
                wait_cnt_d = 8'd0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.div_end) begin
                    hi_d    = bus.div_hi;
                    lo_d    = bus.div_lo;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; async reset clears everything including HI/LO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            div_a_q       <= 32'd0;
            div_b_q       <= 32'd0;
            wait_cnt_q    <= 8'd0;
            done_q        <= 1'b0;
            div0_exc_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            div_a_q       <= div_a_d;
            div_b_q       <= div_b_d;
            wait_cnt_q    <= wait_cnt_d;
            done_q        <= done_d;
            div0_exc_q    <= div0_exc_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // busy and div_start are plain decodes of the state register, so an
    // async reset drops them at once.
    assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.div_start   = (state_q == S_ISSUE);
    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.hi_q        = hi_q;
    assign bus.lo_q        = lo_q;
    assign bus.done        = done_q;
    assign bus.div0_exc    = div0_exc_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
